// File: rtl/map_top_core.sv
// Sliding KxK window generator over a raster pixel stream.
// K-1 line buffers feed the newest window column; the window register drives out directly.
module map_top_core #(
    parameter int row         = 28,
    parameter int data_width  = 16,
    parameter int weight_size = 25,
    parameter int address_num = 5,
    parameter int reg_num     = 20
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         start,
    input  logic        [data_width-1:0] new1,
    input  logic        [data_width-1:0] new2,
    output logic        [data_width-1:0] out [weight_size],
    output logic signed [31:0]           col_num
);

    localparam int K  = address_num;
    localparam int W  = row + address_num - 1;
    localparam int H  = W;
    localparam int LB = reg_num / address_num;
    localparam int CW = $clog2(W);

    localparam logic [CW-1:0] KM1 = CW'(K - 1);
    localparam logic [CW-1:0] WM1 = CW'(W - 1);
    localparam logic [CW-1:0] HM1 = CW'(H - 1);

    logic [CW-1:0] c_q, c_d;
    logic [CW-1:0] r_q, r_d;

    logic [data_width-1:0] lb_q  [LB][W];
    logic [data_width-1:0] lb_d  [LB][W];
    logic [data_width-1:0] win_q [K][K];
    logic [data_width-1:0] win_d [K][K];

    logic signed [31:0] col_q, col_d;

    logic [data_width-1:0] new_col [K];
    logic                  valid;

    logic unused_new2;
    assign unused_new2 = ^new2;

    // Top of the new column is the oldest buffered row; the live pixel sits at the bottom.
    always_comb begin
        for (int unsigned k = 0; k < LB; k++) begin
            new_col[k] = lb_q[k][c_q];
        end
        new_col[K-1] = new1;
    end

    always_comb begin
        c_d   = c_q;
        r_d   = r_q;
        lb_d  = lb_q;
        win_d = win_q;
        col_d = col_q;
        valid = (r_q >= KM1) && (c_q >= KM1);

        if (start) begin
            for (int unsigned i = 0; i < K; i++) begin
                for (int unsigned j = 0; j < K - 1; j++) begin
                    win_d[i][j] = win_q[i][j+1];
                end
                win_d[i][K-1] = new_col[i];
            end

            // Each column of the buffers is a short vertical shift register.
            for (int unsigned k = 0; k < LB - 1; k++) begin
                lb_d[k][c_q] = lb_q[k+1][c_q];
            end
            lb_d[LB-1][c_q] = new1;

            if (valid) begin
                col_d = signed'(32'(c_q - KM1));
            end else begin
                col_d = '1;
            end

            if (c_q == WM1) begin
                c_d = '0;
                r_d = (r_q == HM1) ? '0 : r_q + 1'b1;
            end else begin
                c_d = c_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            c_q   <= '0;
            r_q   <= '0;
            col_q <= '1;
            for (int unsigned k = 0; k < LB; k++) begin
                for (int unsigned x = 0; x < W; x++) begin
                    lb_q[k][x] <= '0;
                end
            end
            for (int unsigned i = 0; i < K; i++) begin
                for (int unsigned j = 0; j < K; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            c_q   <= c_d;
            r_q   <= r_d;
            col_q <= col_d;
            lb_q  <= lb_d;
            win_q <= win_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < K; i++) begin
            for (int unsigned j = 0; j < K; j++) begin
                out[i*K+j] = win_q[i][j];
            end
        end
    end

    assign col_num = col_q;

endmodule

// File: tb/tb_map_top_core.sv
// Scoreboard bench for map_top_core: an image-array reference model predicts every cycle's outputs.
module tb_map_top_core;

    localparam int K   = 5;
    localparam int ROW = 28;
    localparam int W   = ROW + K - 1;
    localparam int H   = W;
    localparam int DW  = 16;
    localparam int WS  = K * K;

    logic                 clk = 1'b0;
    logic                 nrst;
    logic                 start;
    logic        [DW-1:0] new1;
    logic        [DW-1:0] new2;
    logic        [DW-1:0] dout [WS];
    logic signed [31:0]   col_num;

    always #5 clk = ~clk;

    map_top_core #(
        .row        (ROW),
        .data_width (DW),
        .weight_size(WS),
        .address_num(K),
        .reg_num    (K * (K - 1))
    ) dut (
        .clk    (clk),
        .nrst   (nrst),
        .start  (start),
        .new1   (new1),
        .new2   (new2),
        .out    (dout),
        .col_num(col_num)
    );

    typedef struct packed {
        logic signed [31:0]        col;
        logic                      chk;
        logic [WS-1:0][DW-1:0]     win;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   errors = 0;
    int   checks = 0;
    int   frame [H][W];
    int   mr = 0;
    int   mc = 0;

    // Model: the image is a 2D array of the most recent pixel written at each (row, col);
    // a valid window is simply the KxK patch ending at the current pixel.
    task automatic cycle(input bit rst, input bit st, input logic [DW-1:0] pix);
        exp_t e;
        @(negedge clk);
        nrst  = rst;
        start = st;
        new1  = pix;
        new2  = DW'($urandom);
        if (rst) begin
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    frame[y][x] = 0;
            mr = 0;
            mc = 0;
            e.col = -1;
            e.chk = 1'b1;
            e.win = '0;
            last  = e;
        end else if (st) begin
            frame[mr][mc] = int'(pix);
            e.win = '0;
            if (mr >= K - 1 && mc >= K - 1) begin
                e.col = mc - (K - 1);
                e.chk = 1'b1;
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        e.win[i*K+j] = DW'(frame[mr-K+1+i][mc-K+1+j]);
            end else begin
                e.col = -1;
                e.chk = 1'b0;
            end
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr + 1) % H;
            end
            last = e;
        end else begin
            e = last;
        end
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t                  e;
        logic [WS-1:0][DW-1:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int k = 0; k < WS; k++) act[k] = dout[k];
                checks++;
                if ($isunknown({col_num, act})) begin
                    errors++;
                    $display("FAIL xcheck: got col_num=%0d out=%h, need no X/Z", col_num, act);
                end
                checks++;
                if (col_num !== e.col) begin
                    errors++;
                    $display("FAIL col_num @%0t: got %0d, need %0d", $time, col_num, e.col);
                end
                if (e.chk) begin
                    checks++;
                    if (act !== e.win) begin
                        errors++;
                        $display("FAIL window @%0t: got %h need %h", $time, act, e.win);
                    end
                end
            end
        end
    end

    initial begin : driver
        int n;
        nrst  = 1'b1;
        start = 1'b0;
        new1  = '0;
        new2  = '0;

        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, DW'(16'd5));

        // Ramp stream (pixel value = index) with a 3-cycle stall mid-row.
        for (int i = 0; i <= 200; i++) begin
            if (i == 170) begin
                repeat (3) cycle(1'b0, 1'b0, DW'($urandom));
            end
            cycle(1'b0, 1'b1, DW'(i));
        end

        cycle(1'b1, 1'b1, DW'($urandom));

        // Random pixels with random stalls, running past the image wrap.
        n = 0;
        while (n < 1160) begin
            if ($urandom_range(9) == 0) begin
                cycle(1'b0, 1'b0, DW'($urandom));
            end else begin
                cycle(1'b0, 1'b1, DW'($urandom));
                n++;
            end
        end

        cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 180; i++) cycle(1'b0, 1'b1, DW'($urandom));
        cycle(1'b0, 1'b0, '0);

        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, need 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
